// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-outstanding word fetches on the instruction bus
// and queues the returned words in a small FIFO toward the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic        ibus_err,
  input  logic [31:0] ibus_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int          PTR_W = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int          CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD, HALT} state_t;

  state_t               state, state_next;
  logic [31:0]          fetch_pc, pc_base;
  logic [31:0]          buf_data [BUF_DEPTH];
  logic [31:0]          buf_pc   [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_fault;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, count_next;
  logic                 complete, outstanding, push, pop, halt_next, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid = (count != '0);
  assign instruction = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign instr_fault = buf_fault[rd_ptr];

  // A redirect outranks everything: it drops returning data, cancels any pop
  // and clears the halt, so the next request goes to the new target.
  always_comb begin
    complete    = ibus_req & (ibus_ack | ibus_err);
    outstanding = ibus_req & ~complete;
    pc_base     = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : fetch_pc;
    push        = complete & (state == BUSY) & ~redirect_valid;
    pop         = instr_valid & instr_ready & ~redirect_valid;
    halt_next   = 1'b0;
    if (!redirect_valid)
      halt_next = (state == HALT) | (push & ibus_err);
    count_next  = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    issue       = ~outstanding & ~halt_next & (count_next < CNT_W'(BUF_DEPTH));
    if (outstanding)
      state_next = (redirect_valid || state == DISCARD) ? DISCARD : BUSY;
    else if (halt_next)
      state_next = HALT;
    else if (issue)
      state_next = BUSY;
    else
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ibus_req  <= 1'b0;
      ibus_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      buf_fault <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= NOP;
        buf_pc[i]   <= RESET_PC;
      end
    end else begin
      state    <= state_next;
      ibus_req <= outstanding | issue;
      count    <= count_next;
      // fetch_pc always names the next address not yet requested
      if (issue) begin
        ibus_addr <= pc_base;
        fetch_pc  <= pc_base + 32'd4;
      end else begin
        fetch_pc  <= pc_base;
      end
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_data[wr_ptr]  <= ibus_err ? NOP : ibus_rdata;
          buf_pc[wr_ptr]    <= ibus_addr;
          buf_fault[wr_ptr] <= ibus_err;
          wr_ptr            <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entries (legal 2..4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ibus_req, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL have port ibus_addr, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port ibus_ack, input, 1 bit: request completed, ibus_rdata valid.
REQ-008 SHALL have port ibus_err, input, 1 bit: request completed with bus error.
REQ-009 SHALL have port ibus_rdata, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port instr_valid, output, 1 bit: instruction, instr_pc and instr_fault valid toward the decoder.
REQ-011 SHALL have port instr_ready, input, 1 bit: decoder accepts the current instruction.
REQ-012 SHALL have port instruction, output, 32 bits: instruction word to the decoder.
REQ-013 SHALL have port instr_pc, output, 32 bits: address of the current instruction.
REQ-014 SHALL have port instr_fault, output, 1 bit: the current entry came from a bus error.
REQ-015 SHALL have port redirect_valid, input, 1 bit: branch, jump, trap or MRET target change.
REQ-016 SHALL have port redirect_pc, input, 32 bits: new fetch address.

Function
REQ-017 SHALL keep at most one bus request outstanding.
- Once asserted, ibus_req and ibus_addr SHALL hold stable until ibus_ack or ibus_err is sampled high.
REQ-018 SHALL issue a new request only when buffered entries plus outstanding requests < BUF_DEPTH.
- Back-to-back is allowed: a new request may be asserted in the cycle after completion.
REQ-019 SHALL implement states IDLE, BUSY, DISCARD and HALT:
- IDLE: no request outstanding.
- BUSY: a request is outstanding and its data will be kept.
- DISCARD: a request is outstanding and its data will be dropped.
- HALT: fetching stopped after a bus error.
REQ-020 SHALL perform these transitions:
- IDLE->BUSY on request issue.
- BUSY->IDLE/BUSY on ack.
- BUSY->DISCARD on redirect while outstanding.
- DISCARD->IDLE/BUSY on ack or err.
- BUSY->HALT on err.
- HALT->IDLE/BUSY on redirect.
REQ-021 On ack in BUSY, SHALL push {ibus_rdata, ibus_addr, fault=0} into the buffer and advance fetch_pc by 4, with wrap-around modulo 2^32.
REQ-022 On err in BUSY, SHALL push {32'h0000_0013, ibus_addr, fault=1}, enter HALT and issue no further requests until a redirect.
REQ-023 SHALL present the buffer head on instruction/instr_pc/instr_fault with instr_valid = buffer not empty.
- Latency: completion in cycle N gives instr_valid in cycle N+1 when the buffer was empty.
REQ-024 SHALL pop the head when instr_valid and instr_ready are both high.
- While instr_valid=1 and instr_ready=0, the outputs SHALL hold stable.
REQ-025 On redirect_valid, SHALL:
- flush the buffer in the same cycle (instr_valid=0 next cycle);
- load fetch_pc with {redirect_pc[31:2], 2'b00};
- enter DISCARD if a request is outstanding and not completing that cycle.
REQ-026 When redirect and ack/err occur in the same cycle, SHALL drop the returned data.
- The next request SHALL be to the redirect target in the following cycle.
REQ-027 When redirect and a pop occur in the same cycle, SHALL let the flush win, and no entry is delivered after it.
REQ-028 When a push and a pop occur in the same cycle, SHALL keep the buffer count unchanged and preserve order.
REQ-029 SHALL ignore ibus_ack and ibus_err while no request is outstanding.

Reset
REQ-030 While rst_n=0, SHALL hold: ibus_req=0, ibus_addr=RESET_PC, instr_valid=0, instruction=32'h0000_0013, instr_pc=RESET_PC, instr_fault=0, buffer empty, state IDLE.
REQ-031 On rst_n assertion mid-request, SHALL abandon the outstanding request immediately.
- The first request after rst_n deassertion SHALL appear in the first clock cycle after deassertion, with ibus_addr=RESET_PC.

Verification
REQ-032 Streaming: ack every cycle, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8,... with one instruction per cycle after 2-cycle startup.
REQ-033 Backpressure: instr_ready=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 entries buffered, ibus_req=0, outputs stable; on release, order preserved.
REQ-034 Redirect while outstanding: redirect_pc=0x0000_1002 while waiting -> late ack data dropped, next ibus_addr=0x0000_1000, next delivered instr_pc=0x0000_1000.
REQ-035 Same-cycle redirect+ack: ack 0x00A00093 at 0x8 with redirect to 0x40 -> 0x00A00093 never delivered; next request to 0x40.
REQ-036 Bus error at 0x20 -> entry {0x00000013, 0x20, fault=1} delivered, no ibus_req until redirect to 0x100, then fetch resumes at 0x100.
REQ-037 Wrap and reset: fetch at 0xFFFF_FFFC -> next ibus_addr=0x0; rst_n low mid-request -> ibus_req=0 asynchronously, restart at RESET_PC.
